// File: rtl/ttl_scan_pkg.sv
// Shared definitions for the ttl_scan_decoder block: mode encodings and the
// channel-advance helper used by the scan sweep.
package ttl_scan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Result of one scan advance: the channel to move to and whether the
  // sweep wrapped back to channel 0.
  typedef struct packed {
    logic [31:0] next_index;
    logic        wrap;
  } next_index_t;

  // Next channel in the sweep. The last channel, and any out-of-range index
  // loaded from A, both return to channel 0 and raise the wrap flag.
  function automatic next_index_t clamp_next_index(input logic [31:0] index,
                                                   input logic [31:0] width_out);
    next_index_t v_res;
    if (index >= (width_out - 32'd1)) begin
      v_res.next_index = 32'd0;
      v_res.wrap       = 1'b1;
    end else begin
      v_res.next_index = index + 32'd1;
      v_res.wrap       = 1'b0;
    end
    return v_res;
  endfunction

endpackage

// File: rtl/ttl_dwell_counter.sv
// Dwell counter for the scan sweep: counts 0..DWELL-1 and flags the terminal
// count so the top level knows when to move to the next channel.
module ttl_dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic i_clk,
  input  logic i_clear,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_tc,
  output logic o_zero
);

  localparam int            CW   = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] r_count;

  // Count clear/restart to zero, otherwise step and roll over at the terminal count.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_count <= {CW{1'b0}};
    end else if (i_restart) begin
      r_count <= {CW{1'b0}};
    end else if (i_enable) begin
      if (r_count == LAST) begin
        r_count <= {CW{1'b0}};
      end else begin
        r_count <= r_count + CW'(1);
      end
    end else begin
      r_count <= r_count;
    end
  end

  assign o_tc   = (r_count == LAST);
  assign o_zero = (r_count == {CW{1'b0}});

endmodule

// File: rtl/ttl_scan_decoder.sv
// Registered N-to-WIDTH_OUT decoder/demultiplexer with active-low outputs.
// Direct mode latches an address on Load; scan mode sweeps the channels,
// holding each for DWELL clocks and pulsing Wrap on return to channel 0.
// Optional feature: define SCAN_BLANK_EN to blank all outputs for the first
// clock of every channel in scan mode (break-before-make, DWELL>=2 only).
module ttl_scan_decoder
  import ttl_scan_pkg::*;
#(
  parameter int WIDTH_OUT  = 16,
  parameter int WIDTH_IN   = $clog2(WIDTH_OUT),
  parameter int DWELL      = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                 Clk,
  input  logic                 Clear,
  input  logic                 Enable1_bar,
  input  logic                 Enable2_bar,
  input  logic                 Mode,
  input  logic                 Load,
  input  logic [WIDTH_IN-1:0]  A,
  output logic [WIDTH_OUT-1:0] Y,
  output logic [WIDTH_IN-1:0]  Index,
  output logic                 Wrap
);

`ifdef SCAN_BLANK_EN
  localparam logic BLANK_ON = 1'b1;
`else
  localparam logic BLANK_ON = 1'b0;
`endif

  // Output delays are simulation annotations only; hardware drives Y directly.
  if ((DELAY_RISE < 0) || (DELAY_FALL < 0)) begin : g_bad_delay
    $error("ttl_scan_decoder: DELAY_RISE/DELAY_FALL must be non-negative");
  end
  if ((DWELL < 1) || (DWELL > 65535)) begin : g_bad_dwell
    $error("ttl_scan_decoder: DWELL must be in 1..65535");
  end

  logic [WIDTH_IN-1:0]  r_index;
  logic                 r_wrap;
  logic                 w_enabled;
  logic                 w_dwell_tc;
  logic                 w_dwell_zero;
  logic                 w_blank;
  logic [WIDTH_IN-1:0]  w_next_index;
  logic                 w_next_wrap;
  next_index_t          w_clamp;
  logic [WIDTH_OUT-1:0] w_y;

  assign w_enabled = ~Enable1_bar & ~Enable2_bar;

  // Direct mode parks the dwell count at zero, so entering scan mode always
  // starts a fresh dwell on the current channel.
  ttl_dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .i_clk     (Clk),
    .i_clear   (Clear),
    .i_restart (w_enabled & (Load | (Mode == MODE_DIRECT))),
    .i_enable  (w_enabled & (Mode == MODE_SCAN)),
    .o_tc      (w_dwell_tc),
    .o_zero    (w_dwell_zero)
  );

  assign w_clamp      = clamp_next_index(32'(r_index), 32'(WIDTH_OUT));
  assign w_next_index = WIDTH_IN'(w_clamp.next_index);
  assign w_next_wrap  = w_clamp.wrap;

  // Channel and wrap registers: Clear > disabled > Load > scan advance.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      r_index <= {WIDTH_IN{1'b0}};
      r_wrap  <= 1'b0;
    end else if (!w_enabled) begin
      r_index <= r_index;
      r_wrap  <= 1'b0;
    end else if (Load) begin
      r_index <= A;
      r_wrap  <= 1'b0;
    end else if ((Mode == MODE_SCAN) && w_dwell_tc) begin
      r_index <= w_next_index;
      r_wrap  <= w_next_wrap;
    end else begin
      r_index <= r_index;
      r_wrap  <= 1'b0;
    end
  end

  // Break-before-make: blank the first clock of each channel in scan mode.
  assign w_blank = BLANK_ON & (Mode == MODE_SCAN) & (DWELL >= 2) & w_dwell_zero;

  // Active-low one-hot decode of the current channel, gated by the enables.
  always_comb begin
    w_y = {WIDTH_OUT{1'b1}};
    for (int i = 0; i < WIDTH_OUT; i++) begin
      if (w_enabled && !w_blank && (r_index == WIDTH_IN'(i))) begin
        w_y[i] = 1'b0;
      end else begin
        w_y[i] = 1'b1;
      end
    end
  end

  assign Y     = w_y;
  assign Index = r_index;
  assign Wrap  = r_wrap;

endmodule

// File: tb/tb_ttl_scan_decoder.sv
// Self-checking bench for ttl_scan_decoder: three instances (16/DWELL=4,
// 10/DWELL=1, 16/DWELL=3) share one stimulus stream and are compared each
// cycle against a behavioural model; directed literal checks pin the model.
module tb_ttl_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear, e1, e2, mode, load;
  logic [3:0] a;

  logic [15:0] y_a;  logic [3:0] idx_a;  logic wrap_a;
  logic [9:0]  y_b;  logic [3:0] idx_b;  logic wrap_b;
  logic [15:0] y_c;  logic [3:0] idx_c;  logic wrap_c;

  int checks   = 0;
  int failures = 0;

`ifdef SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  ttl_scan_decoder #(.WIDTH_OUT(16), .DWELL(4)) u_dut_a (
    .Clk(clk), .Clear(clear), .Enable1_bar(e1), .Enable2_bar(e2), .Mode(mode),
    .Load(load), .A(a), .Y(y_a), .Index(idx_a), .Wrap(wrap_a));

  ttl_scan_decoder #(.WIDTH_OUT(10), .DWELL(1)) u_dut_b (
    .Clk(clk), .Clear(clear), .Enable1_bar(e1), .Enable2_bar(e2), .Mode(mode),
    .Load(load), .A(a), .Y(y_b), .Index(idx_b), .Wrap(wrap_b));

  ttl_scan_decoder #(.WIDTH_OUT(16), .DWELL(3)) u_dut_c (
    .Clk(clk), .Clear(clear), .Enable1_bar(e1), .Enable2_bar(e2), .Mode(mode),
    .Load(load), .A(a), .Y(y_c), .Index(idx_c), .Wrap(wrap_c));

  // Behavioural model state per instance: channel, clocks spent on it, wrap pulse.
  int m_idx [3];
  int m_cnt [3];
  bit m_wrap[3];
  int wo    [3] = '{16, 10, 16};
  int dw    [3] = '{4, 1, 3};
  bit cmp_en = 1'b0;
  int fail_prints = 0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_wrap[k] = 1'b0;
    end
  end

  // Model: apply the decoder rules to the inputs present at each rising edge.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (clear) begin
        m_idx[k] <= 0; m_cnt[k] <= 0; m_wrap[k] <= 1'b0;
      end else if (e1 || e2) begin
        m_wrap[k] <= 1'b0;
      end else if (load) begin
        m_idx[k] <= int'(a); m_cnt[k] <= 0; m_wrap[k] <= 1'b0;
      end else if (!mode) begin
        m_cnt[k] <= 0; m_wrap[k] <= 1'b0;
      end else if (m_cnt[k] == dw[k] - 1) begin
        m_cnt[k] <= 0;
        if (m_idx[k] >= wo[k] - 1) begin
          m_idx[k] <= 0; m_wrap[k] <= 1'b1;
        end else begin
          m_idx[k] <= m_idx[k] + 1; m_wrap[k] <= 1'b0;
        end
      end else begin
        m_cnt[k] <= m_cnt[k] + 1; m_wrap[k] <= 1'b0;
      end
    end
  end

  function automatic int exp_y(int k);
    int  all1;
    bit  en;
    bit  blank;
    all1  = (1 << wo[k]) - 1;
    en    = !e1 && !e2;
    blank = BLANK && mode && (dw[k] >= 2) && (m_cnt[k] == 0);
    if (en && !blank && (m_idx[k] < wo[k])) return all1 & ~(1 << m_idx[k]);
    return all1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
    end
  endtask

  // Compare process: every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("y_a",    32'(y_a),    32'(exp_y(0)));
      chk("idx_a",  32'(idx_a),  32'(m_idx[0]));
      chk("wrap_a", 32'(wrap_a), 32'(m_wrap[0]));
      chk("y_b",    32'(y_b),    32'(exp_y(1)));
      chk("idx_b",  32'(idx_b),  32'(m_idx[1]));
      chk("wrap_b", 32'(wrap_b), 32'(m_wrap[1]));
      chk("y_c",    32'(y_c),    32'(exp_y(2)));
      chk("idx_c",  32'(idx_c),  32'(m_idx[2]));
      chk("wrap_c", 32'(wrap_c), 32'(m_wrap[2]));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int expv;
    clear = 1'b1; e1 = 1'b0; e2 = 1'b0; mode = 1'b0; load = 1'b0; a = 4'd0;

    // Reset state, then disable gating.
    step(1);
    cmp_en = 1'b1;
    chk("t1_y_reset",   32'(y_a),    32'h0000_FFFE);
    chk("t1_idx_reset", 32'(idx_a),  32'd0);
    chk("t1_wrap_reset",32'(wrap_a), 32'd0);
    clear = 1'b0; e1 = 1'b1;
    #1;
    chk("t1_y_disabled", 32'(y_a), 32'h0000_FFFF);
    e1 = 1'b0;

    // Direct load and hold.
    load = 1'b1; a = 4'd9;
    step(1);
    chk("t2_y_load",   32'(y_a),   32'h0000_FDFF);
    chk("t2_idx_load", 32'(idx_a), 32'd9);
    load = 1'b0; a = 4'd3;
    step(1);
    chk("t2_y_hold", 32'(y_a), 32'h0000_FDFF);

    // Full scan sweep with DWELL=4.
    clear = 1'b1;
    step(1);
    clear = 1'b0; mode = 1'b1;
    step(4);
    chk("t3_idx_step1", 32'(idx_a), 32'd1);
    step(59);
    chk("t3_idx_last", 32'(idx_a), 32'd15);
    chk("t3_wrap_pre", 32'(wrap_a), 32'd0);
    step(1);
    chk("t3_idx_wrap", 32'(idx_a),  32'd0);
    chk("t3_wrap_set", 32'(wrap_a), 32'd1);
    step(1);
    chk("t3_wrap_clr", 32'(wrap_a), 32'd0);

    // Mid-sweep load restarts the dwell; then disable freezes.
    load = 1'b1; a = 4'd5;
    step(1);
    load = 1'b0;
    step(2);
    load = 1'b1; a = 4'd12;
    step(1);
    load = 1'b0;
    chk("t4_idx_load", 32'(idx_a), 32'd12);
    step(3);
    chk("t4_idx_dwell", 32'(idx_a), 32'd12);
    step(1);
    chk("t4_idx_next", 32'(idx_a), 32'd13);
    e2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t4_y_frozen",   32'(y_a),   32'h0000_FFFF);
      chk("t4_idx_frozen", 32'(idx_a), 32'd13);
    end
    e2 = 1'b0;

    // WIDTH_OUT=10, DWELL=1: out-of-range load, wrap, and Clear beating a wrap.
    load = 1'b1; a = 4'd13;
    step(1);
    load = 1'b0;
    chk("t5_y_oor",   32'(y_b),   32'h0000_03FF);
    chk("t5_idx_oor", 32'(idx_b), 32'd13);
    step(1);
    chk("t5_idx_wrap", 32'(idx_b),  32'd0);
    chk("t5_wrap_set", 32'(wrap_b), 32'd1);
    load = 1'b1; a = 4'd9;
    step(1);
    load = 1'b0; clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("t5_clear_wrap", 32'(wrap_b), 32'd0);
    chk("t5_clear_idx",  32'(idx_b),  32'd0);

    // DWELL=3 pattern, with or without blanking.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (BLANK && (c % 3 == 0)) expv = 32'h0000_FFFF;
      else expv = 32'h0000_FFFF & ~(32'd1 << (c / 3));
      chk("t6_pattern", 32'(y_c), 32'(expv));
      step(1);
    end

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 3000; i++) begin
      clear = ($urandom % 100) == 0;
      e1    = ($urandom % 16) == 0;
      e2    = ($urandom % 16) == 0;
      load  = ($urandom % 10) == 0;
      a     = 4'($urandom);
      if (($urandom % 40) == 0) mode = ~mode;
      step(1);
    end

    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
